// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift left/right, parallel load, with a wrap counter and shift_done pulse.
// Optional rotate mode is enabled by defining UNIV_SR_ROTATE_EN.
module univ_shift_reg #(
    parameter  int unsigned WIDTH = 8,
    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] load_data,
    input  logic             sin_r,
    input  logic             sin_l,
`ifdef UNIV_SR_ROTATE_EN
    input  logic             rotate,
`endif
    output logic [WIDTH-1:0] data_out,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             shift_done
);

    typedef enum logic [1:0] {
        MODE_HOLD  = 2'b00,
        MODE_SHL   = 2'b01,
        MODE_SHR   = 2'b10,
        MODE_LOAD  = 2'b11
    } mode_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH - 1);

    mode_t            mode_e;
    logic             fill_r;
    logic             fill_l;
    logic             cnt_wrap;
    logic [CNT_W-1:0] cnt_next;

    assign mode_e = mode_t'(mode);

    // Bits shifted in at each end; rotate feeds back the bit falling off the opposite end.
    always_comb begin
        fill_r = sin_r;
        fill_l = sin_l;
`ifdef UNIV_SR_ROTATE_EN
        if (rotate) begin
            fill_r = data_out[WIDTH-1];
            fill_l = data_out[0];
        end
`endif
    end

    always_comb begin
        cnt_wrap = (shift_cnt == CNT_MAX);
        cnt_next = cnt_wrap ? '0 : shift_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            shift_cnt  <= '0;
            shift_done <= 1'b0;
        end else if (!en) begin
            shift_done <= 1'b0;
        end else begin
            case (mode_e)
                MODE_HOLD: begin
                    shift_done <= 1'b0;
                end
                MODE_SHL: begin
                    data_out   <= {data_out[WIDTH-2:0], fill_r};
                    shift_cnt  <= cnt_next;
                    shift_done <= cnt_wrap;
                end
                MODE_SHR: begin
                    data_out   <= {fill_l, data_out[WIDTH-1:1]};
                    shift_cnt  <= cnt_next;
                    shift_done <= cnt_wrap;
                end
                default: begin
                    data_out   <= load_data;
                    shift_cnt  <= '0;
                    shift_done <= 1'b0;
                end
            endcase
        end
    end

    assign sout_l = data_out[WIDTH-1];
    assign sout_r = data_out[0];

endmodule

// File: tb/tb_univ_shift_reg.sv
// Self-checking bench for univ_shift_reg (WIDTH=8): arithmetic reference model checked every cycle
// plus directed literal checks; define UNIV_SR_ROTATE_EN to also exercise rotate.
module tb_univ_shift_reg;

    localparam int unsigned W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [1:0]   mode;
    logic [W-1:0] load_data;
    logic         sin_r;
    logic         sin_l;
    logic         rotate;
    logic [W-1:0] data_out;
    logic         sout_l;
    logic         sout_r;
    logic [2:0]   shift_cnt;
    logic         shift_done;

    int checks = 0;
    int fails  = 0;

    univ_shift_reg #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .mode      (mode),
        .load_data (load_data),
        .sin_r     (sin_r),
        .sin_l     (sin_l),
`ifdef UNIV_SR_ROTATE_EN
        .rotate    (rotate),
`endif
        .data_out  (data_out),
        .sout_l    (sout_l),
        .sout_r    (sout_r),
        .shift_cnt (shift_cnt),
        .shift_done(shift_done)
    );

    always #5 clk = ~clk;

    // Reference model: value as an integer, plus a running count of shifts since the last load.
    int unsigned m_val;
    int unsigned m_shifts;
    bit          m_done;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_val = 0; m_shifts = 0; m_done = 0;
        end else begin
            m_done = 0;
            if (en) begin
                if (mode == 2'd3) begin
                    m_val = load_data; m_shifts = 0;
                end else if (mode == 2'd1 || mode == 2'd2) begin
                    int unsigned in_bit;
                    int unsigned top;
                    top    = m_val / (2 ** (W - 1));
                    in_bit = (mode == 2'd1) ? sin_r : sin_l;
`ifdef UNIV_SR_ROTATE_EN
                    if (rotate) in_bit = (mode == 2'd1) ? top : m_val % 2;
`endif
                    if (mode == 2'd1) m_val = (m_val * 2 + in_bit) % (2 ** W);
                    else              m_val = m_val / 2 + in_bit * (2 ** (W - 1));
                    m_shifts = m_shifts + 1;
                    m_done   = (m_shifts % W == 0);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("model data_out",   32'(data_out),   32'(m_val));
        check("model sout_l",     32'(sout_l),     32'(m_val / (2 ** (W - 1))));
        check("model sout_r",     32'(sout_r),     32'(m_val % 2));
        check("model shift_cnt",  32'(shift_cnt),  32'(m_shifts % W));
        check("model shift_done", 32'(shift_done), 32'(m_done));
    end

    task automatic apply(input logic e, input logic [1:0] md, input logic [7:0] ld,
                         input logic sr, input logic sl, input logic rot);
        en = e; mode = md; load_data = ld; sin_r = sr; sin_l = sl; rotate = rot;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_seq [8];
    int done_hits;

    initial begin
        rst = 1'b1; en = 1'b0; mode = 2'd0; load_data = '0;
        sin_r = 1'b0; sin_l = 1'b0; rotate = 1'b0;
        #12;
        check("reset data_out",   32'(data_out),   32'h0);
        check("reset shift_cnt",  32'(shift_cnt),  32'h0);
        check("reset shift_done", 32'(shift_done), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Async reset mid-run: 0xFF with 5 shifts counted
        apply(1, 2'd3, 8'hFF, 0, 0, 0);
        repeat (5) apply(1, 2'd1, 8'h00, 1, 0, 0);
        check("pre-rst data_out", 32'(data_out),  32'hFF);
        check("pre-rst shift_cnt", 32'(shift_cnt), 32'd5);
        #2 rst = 1'b1;
        #1;
        check("async rst data_out",   32'(data_out),   32'h0);
        check("async rst shift_cnt",  32'(shift_cnt),  32'h0);
        check("async rst shift_done", 32'(shift_done), 32'h0);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Load 0xA5 then 8 left shifts with sin_r=1
        exp_seq = '{8'h4B, 8'h97, 8'h2F, 8'h5F, 8'hBF, 8'h7F, 8'hFF, 8'hFF};
        apply(1, 2'd3, 8'hA5, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            apply(1, 2'd1, 8'h00, 1, 0, 0);
            check("shl A5 data_out", 32'(data_out), 32'(exp_seq[i]));
            check("shl A5 shift_done", 32'(shift_done), (i == 7) ? 32'd1 : 32'd0);
        end
        check("shl A5 cnt wrapped", 32'(shift_cnt), 32'd0);

        // Load 0x80, 3 right shifts, then en=0 for 4 cycles
        apply(1, 2'd3, 8'h80, 0, 0, 0);
        repeat (3) apply(1, 2'd2, 8'h00, 0, 0, 0);
        check("shr data_out", 32'(data_out), 32'h10);
        check("shr sout_r",   32'(sout_r),   32'd0);
        check("shr shift_cnt", 32'(shift_cnt), 32'd3);
        repeat (4) apply(0, 2'd1, 8'hFF, 1, 1, 0);
        check("en0 data_out",   32'(data_out),   32'h10);
        check("en0 shift_cnt",  32'(shift_cnt),  32'd3);
        check("en0 shift_done", 32'(shift_done), 32'd0);

        // 5 shifts, 2 holds, 3 shifts: done on the last shift
        apply(1, 2'd3, 8'h12, 0, 0, 0);
        repeat (5) apply(1, 2'd2, 8'h00, 0, 1, 0);
        repeat (2) apply(1, 2'd0, 8'h00, 0, 0, 0);
        check("hold keeps cnt", 32'(shift_cnt), 32'd5);
        repeat (2) apply(1, 2'd1, 8'h00, 0, 0, 0);
        check("mixed no early done", 32'(shift_done), 32'd0);
        apply(1, 2'd1, 8'h00, 1, 0, 0);
        check("mixed done", 32'(shift_done), 32'd1);

        // 7 shifts then load 0x3C
        repeat (7) apply(1, 2'd1, 8'h00, 0, 0, 0);
        check("7 shifts cnt", 32'(shift_cnt), 32'd7);
        apply(1, 2'd3, 8'h3C, 0, 0, 0);
        check("load wins data_out",   32'(data_out),   32'h3C);
        check("load wins shift_cnt",  32'(shift_cnt),  32'd0);
        check("load wins shift_done", 32'(shift_done), 32'd0);

        // 16 continuous left shifts: done on 8 and 16 only
        done_hits = 0;
        for (int i = 1; i <= 16; i++) begin
            apply(1, 2'd1, 8'h00, i[0], 0, 0);
            if (shift_done) done_hits++;
            check("cont shift_done", 32'(shift_done), (i == 8 || i == 16) ? 32'd1 : 32'd0);
        end
        check("cont done count", 32'(done_hits), 32'd2);

`ifdef UNIV_SR_ROTATE_EN
        apply(1, 2'd3, 8'h81, 0, 0, 0);
        apply(1, 2'd1, 8'h00, 0, 0, 1);
        check("rotl data_out", 32'(data_out), 32'h03);
        apply(1, 2'd2, 8'h00, 0, 0, 1);
        apply(1, 2'd2, 8'h00, 0, 0, 1);
        check("rotr data_out", 32'(data_out), 32'hC0);
`endif

        apply(1, 2'd0, 8'h00, 0, 0, 0);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
